// File: rtl/fifo_ctrl_256x4.sv
// fifo_ctrl_256x4: push/pop controller driving a 256x4 dual-port RAM with registered read address.
// Define FIFO_CTRL_WATERMARK_EN to add the ALMOST_FULL/ALMOST_EMPTY outputs and their thresholds.
module fifo_ctrl_256x4 #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AFULL_TH  = 240,
    parameter int AEMPTY_TH = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              FULL,
    input  logic              RD_EN,
    output logic              EMPTY,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [ADDR_W-1:0] ADDRA,
    output logic              WEA,
    output logic [DATA_W-1:0] RAM_DIN,
    output logic [ADDR_W-1:0] ADDRB,
    input  logic [DATA_W-1:0] RAM_DOUT
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY
`endif
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, count_nxt;
    logic              push_ok, pop_ok;
    assign FULL    = count == FULL_CNT;
    assign EMPTY   = count == '0;
    assign push_ok = WR_EN & ~FULL;
    assign pop_ok  = RD_EN & ~EMPTY;
    assign COUNT   = count;
    assign ADDRA   = wr_ptr;
    assign ADDRB   = rd_ptr;
    assign WEA     = push_ok;
    assign RAM_DIN = WR_DATA;
    assign DOUT    = RAM_DOUT;
    always_comb begin
        count_nxt = (push_ok && !pop_ok) ? count + 1'b1 :
                    (pop_ok && !push_ok) ? count - 1'b1 : count;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            DOUT_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
            UNDERFLOW  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            DOUT_VALID <= pop_ok;
            if (WR_EN && FULL) OVERFLOW <= 1'b1;
            if (RD_EN && EMPTY) UNDERFLOW <= 1'b1;
        end
    end
`ifdef FIFO_CTRL_WATERMARK_EN
    // registered from count_nxt so the flags change on the same edge as COUNT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            ALMOST_FULL  <= int'(count_nxt) >= AFULL_TH;
            ALMOST_EMPTY <= int'(count_nxt) <= AEMPTY_TH;
        end
    end
`endif
endmodule
